alu_seq: RTL

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It is WIDTH bits wide and has registered results and flags. It adds arithmetic shifts by a variable amount, signed and unsigned compare, and a multi-cycle unsigned multiply built as an iterative shift-add. It sits between operand-fetch and writeback, using valid/ready on both sides.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked WIDTH-bit ALU with registered result/flags and an
//               iterative shift-add unsigned multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW:0]       cnt_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               zero_q, carry_q, overflow_q, negative_q, err_q;

    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v, w_err;
    logic [SHW-1:0]     w_shamt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_accept, w_mul_last;

    assign w_shamt    = b[SHW-1:0];
    assign w_accept   = in_valid && (state_q == S_IDLE);
    assign w_mul_last = (cnt_q == CNT_LAST);
    assign w_acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle datapath; MUL is excluded here and handled by the iterator.
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        w_diff = {1'b0, a} - {1'b0, b};
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_err  = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $signed(a) >>> w_shamt;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL:  w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:   if (w_mul_last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (w_accept) begin
            if (op == OP_MUL) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                cnt_q    <= CNT_INIT;
            end else begin
                result_q    <= w_res;
                result_hi_q <= '0;
                zero_q      <= (w_res == '0);
                carry_q     <= w_c;
                overflow_q  <= w_v;
                negative_q  <= w_res[WIDTH-1];
                err_q       <= w_err;
            end
        end else if (state_q == S_MUL) begin
            acc_q    <= w_acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_LAST;
            // Last multiplier bit: the partial sum this cycle is the full product.
            if (w_mul_last) begin
                result_q    <= w_acc_nxt[WIDTH-1:0];
                result_hi_q <= w_acc_nxt[2*WIDTH-1:WIDTH];
                zero_q      <= (w_acc_nxt == '0);
                carry_q     <= 1'b0;
                overflow_q  <= 1'b0;
                negative_q  <= w_acc_nxt[2*WIDTH-1];
                err_q       <= 1'b0;
            end
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign err       = err_q;

endmodule
`default_nettype wire
